// File: rtl/real_autorange_pkg.sv
// Shared types and elaboration-time helpers for the real_autorange converter.
// Rounding is selected by the AUTORANGE_ROUND_EN macro (see autorange_round).
package real_autorange_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Largest value that fits in an m-bit signed mantissa.
  function automatic int fit_max(input int m);
    return (32'sd1 <<< (m - 1)) - 32'sd1;
  endfunction

  function automatic int fit_min(input int m);
    return -(32'sd1 <<< (m - 1));
  endfunction

  // Values in [small_min, small_max] still have a redundant sign bit.
  function automatic int small_max(input int m);
    return (32'sd1 <<< (m - 2)) - 32'sd1;
  endfunction

  function automatic int small_min(input int m);
    return -(32'sd1 <<< (m - 2));
  endfunction

  // Narrowest signed exponent covering [-(m-1), in_w-m+1].
  function automatic int min_exp_width(input int in_w, input int m);
    int w;
    w = 32;
    for (int e = 32; e >= 2; e--) begin
      if (((32'sd1 <<< (e - 1)) >= (m - 1)) &&
          (((32'sd1 <<< (e - 1)) - 32'sd1) >= (in_w - m + 1))) begin
        w = e;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/real_autorange_round.sv
// Final rounding of the normalized working value into the output mantissa.
// With AUTORANGE_ROUND_EN the guard bit is added and a carry into the sign bit is renormalized;
// without it the value is passed through (truncation) and the guard is ignored.
module autorange_round #(
  parameter int MANT_WIDTH = 8,
  parameter int EXP_WIDTH  = 6
) (
  input  logic signed [MANT_WIDTH-1:0] work_mant,
  input  logic signed [EXP_WIDTH-1:0]  work_exp,
  input  logic                         guard,
  output logic signed [MANT_WIDTH-1:0] mant,
  output logic signed [EXP_WIDTH-1:0]  exp
);

`ifdef AUTORANGE_ROUND_EN
  localparam logic signed [MANT_WIDTH:0]   OVF_VAL = {2'b01, {(MANT_WIDTH-1){1'b0}}};
  localparam logic signed [MANT_WIDTH-1:0] RENORM  = {2'b01, {(MANT_WIDTH-2){1'b0}}};
  localparam logic signed [EXP_WIDTH-1:0]  EXP_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

  logic signed [MANT_WIDTH:0] sum_s;

  // Add the guard one bit wider so a carry to +2^(M-1) is visible and folded back.
  always_comb begin
    sum_s = {work_mant[MANT_WIDTH-1], work_mant} + {{MANT_WIDTH{1'b0}}, guard};
    mant  = sum_s[MANT_WIDTH-1:0];
    exp   = work_exp;
    if (sum_s == OVF_VAL) begin
      mant = RENORM;
      exp  = work_exp + EXP_ONE;
    end else begin
      mant = sum_s[MANT_WIDTH-1:0];
      exp  = work_exp;
    end
  end
`else
  logic unused_guard_s;

  assign unused_guard_s = guard;
  assign mant           = work_mant;
  assign exp            = work_exp;
`endif

endmodule

// File: rtl/real_autorange.sv
// Sequential auto-ranging integer -> (mantissa, exponent) converter, value = out_mant * 2^out_exp.
// Define AUTORANGE_ROUND_EN for round-half-up; otherwise the result is truncated.
module real_autorange
  import real_autorange_pkg::*;
#(
  parameter int IN_WIDTH   = 16,
  parameter int MANT_WIDTH = 8,
  parameter int EXP_WIDTH  = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [IN_WIDTH-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [MANT_WIDTH-1:0] out_mant,
  output logic signed [EXP_WIDTH-1:0]  out_exp
);

  generate
    if ((IN_WIDTH < MANT_WIDTH) || (MANT_WIDTH < 3) ||
        (EXP_WIDTH < min_exp_width(IN_WIDTH, MANT_WIDTH))) begin : g_bad_params
      $error("real_autorange: illegal IN_WIDTH/MANT_WIDTH/EXP_WIDTH combination");
    end
  endgenerate

  localparam logic signed [IN_WIDTH-1:0]  FIT_MAX   = IN_WIDTH'(fit_max(MANT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0]  FIT_MIN   = IN_WIDTH'(fit_min(MANT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0]  SMALL_MAX = IN_WIDTH'(small_max(MANT_WIDTH));
  localparam logic signed [IN_WIDTH-1:0]  SMALL_MIN = IN_WIDTH'(small_min(MANT_WIDTH));
  localparam logic signed [EXP_WIDTH-1:0] EXP_ONE   = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

  state_t                       state_r;
  logic signed [IN_WIDTH-1:0]   work_r;
  logic signed [EXP_WIDTH-1:0]  exp_r;
  logic                         guard_r;

  logic                         zero_s;
  logic                         fits_s;
  logic                         norm_s;
  logic signed [MANT_WIDTH-1:0] rnd_mant_s;
  logic signed [EXP_WIDTH-1:0]  rnd_exp_s;

  assign zero_s = (work_r == {IN_WIDTH{1'b0}});
  assign fits_s = (work_r >= FIT_MIN) && (work_r <= FIT_MAX);
  assign norm_s = fits_s && ((work_r < SMALL_MIN) || (work_r > SMALL_MAX));

  // Only the low MANT_WIDTH bits matter here: ROUND is reached only once the value fits.
  autorange_round #(
    .MANT_WIDTH (MANT_WIDTH),
    .EXP_WIDTH  (EXP_WIDTH)
  ) u_round (
    .work_mant (work_r[MANT_WIDTH-1:0]),
    .work_exp  (exp_r),
    .guard     (guard_r),
    .mant      (rnd_mant_s),
    .exp       (rnd_exp_s)
  );

  // Control FSM: accept, normalize one bit per cycle, round, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      work_r    <= {IN_WIDTH{1'b0}};
      exp_r     <= {EXP_WIDTH{1'b0}};
      guard_r   <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_mant  <= {MANT_WIDTH{1'b0}};
      out_exp   <= {EXP_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            work_r   <= in_data;
            exp_r    <= {EXP_WIDTH{1'b0}};
            guard_r  <= 1'b0;
            in_ready <= 1'b0;
            state_r  <= NORM;
          end else begin
            in_ready <= 1'b1;
          end
        end
        NORM: begin
          if (zero_s || norm_s) begin
            state_r <= ROUND;
          end else if (!fits_s) begin
            // Arithmetic right shift; remember the bit that falls off for rounding.
            work_r  <= {work_r[IN_WIDTH-1], work_r[IN_WIDTH-1:1]};
            guard_r <= work_r[0];
            exp_r   <= exp_r + EXP_ONE;
          end else begin
            work_r  <= {work_r[IN_WIDTH-2:0], 1'b0};
            guard_r <= 1'b0;
            exp_r   <= exp_r - EXP_ONE;
          end
        end
        ROUND: begin
          out_mant  <= rnd_mant_s;
          out_exp   <= rnd_exp_s;
          out_valid <= 1'b1;
          state_r   <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_real_autorange.sv
// Directed-vector bench for real_autorange with hand-computed results for both rounding modes.
module tb_real_autorange;

`ifdef AUTORANGE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [7:0]  out_mant;
  logic signed [5:0]  out_exp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  real_autorange dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp)
  );

  task automatic check_val(input string tag, input logic signed [31:0] act,
                           input logic signed [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  // Send one sample, measure latency, optionally stall the output, then complete the handshake.
  task automatic convert(input string tag, input logic signed [15:0] d, input int em,
                         input int ee, input int lat, input int stall);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_in_ready"}, in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'sd0;
    check_val({tag, "_busy"}, in_ready, 0);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    check_val({tag, "_latency"}, n, lat);
    check_val({tag, "_mant"}, out_mant, em);
    check_val({tag, "_exp"}, out_exp, ee);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check_val({tag, "_stall_valid"}, out_valid, 1);
      check_val({tag, "_stall_mant"}, out_mant, em);
      check_val({tag, "_stall_exp"}, out_exp, ee);
      check_val({tag, "_stall_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_done_valid"}, out_valid, 0);
    check_val({tag, "_done_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'sd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_mant", out_mant, 0);
    check_val("rst_exp", out_exp, 0);
    rst = 1'b0;

    convert("d1000", 16'sd1000, 125, 3, 5, 0);
    convert("d255", 16'sd255, RND ? 64 : 127, RND ? 2 : 1, 3, 0);
    convert("d251", 16'sd251, RND ? 126 : 125, 1, 3, 0);
    convert("dm251", -16'sd251, RND ? -125 : -126, 1, 3, 0);
    convert("dmax", 16'sd32767, RND ? 64 : 127, RND ? 9 : 8, 10, 0);
    convert("dmin", -16'sd32768, -128, 8, 10, 0);
    convert("d5", 16'sd5, 80, -4, 6, 0);
    convert("dm1", -16'sd1, -128, -7, 9, 0);
    convert("d0", 16'sd0, 0, 0, 2, 0);
    convert("d100", 16'sd100, 100, 0, 2, 0);
    convert("stall", 16'sd1000, 125, 3, 5, 10);

    // Reset in the middle of NORM must drop the sample.
    in_data  = -16'sd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 16'sd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_in_ready", in_ready, 0);
    check_val("midrst_out_valid", out_valid, 0);
    check_val("midrst_mant", out_mant, 0);
    check_val("midrst_exp", out_exp, 0);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    check_val("midrst_no_emit", seen, 0);
    convert("after_rst", 16'sd5, 80, -4, 6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
